// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment digit scanner with double-buffered value and leading-zero blanking
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK = 16,
  parameter bit SEL_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dps,
  input  logic                  load,
  input  logic                  lzb_en,
  output logic [3:0]            digit_data,
  output logic                  digit_dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_start
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{SEL_ACTIVE_LOW}};
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic run_q, run_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d, shad_val_q, shad_val_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d, shad_dp_q, shad_dp_d;
  logic pend_flag_q, pend_flag_d;
  logic [3:0] digit_data_q, digit_data_d;
  logic digit_dp_q, digit_dp_d;
  logic [DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic frame_start_q, frame_start_d;
  logic [DIGITS-1:0] blank;
  logic wrap, swap, hi_zero;
  // run_q holds the scan in a pre-start state so the first edge after reset enters slot (0,0)
  always_comb begin
    wrap = cnt_q == CW'(PRESCALE - 1);
    run_d = 1'b1;
    cnt_d = !run_q || wrap ? '0 : cnt_q + 1'b1;
    idx_d = !run_q ? '0 : !wrap ? idx_q : idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
    swap = idx_d == '0 && cnt_d == '0 && pend_flag_q;
    shad_val_d = swap ? pend_val_q : shad_val_q;
    shad_dp_d = swap ? pend_dp_q : shad_dp_q;
    pend_val_d = load ? value : pend_val_q;
    pend_dp_d = load ? dps : pend_dp_q;
    pend_flag_d = load || (pend_flag_q && !swap);
    hi_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      hi_zero = hi_zero && shad_val_d[4*k +: 4] == 4'h0;
      blank[k] = lzb_en && k != 0 && hi_zero && !shad_dp_d[k];
    end
    digit_data_d = shad_val_d[{idx_d, 2'b00} +: 4];
    digit_dp_d = shad_dp_d[idx_d];
    digit_sel_d = SEL_OFF ^ (cnt_d >= CW'(BLANK) && !blank[idx_d] ? DIGITS'(1) << idx_d : '0);
    frame_start_d = idx_d == '0 && cnt_d == '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      run_q <= 1'b0;
      pend_val_q <= '0;
      pend_dp_q <= '0;
      pend_flag_q <= 1'b0;
      shad_val_q <= '0;
      shad_dp_q <= '0;
      digit_data_q <= '0;
      digit_dp_q <= 1'b0;
      digit_sel_q <= SEL_OFF;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      run_q <= run_d;
      pend_val_q <= pend_val_d;
      pend_dp_q <= pend_dp_d;
      pend_flag_q <= pend_flag_d;
      shad_val_q <= shad_val_d;
      shad_dp_q <= shad_dp_d;
      digit_data_q <= digit_data_d;
      digit_dp_q <= digit_dp_d;
      digit_sel_q <= digit_sel_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign digit_data = digit_data_q;
  assign digit_dp = digit_dp_q;
  assign digit_sel = digit_sel_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: table vectors, corner sequences and random stimulus against a frame-time model
module tb_seg_scan_ctrl;
  localparam int D = 4, P = 8, B = 2, F = D * P;
  logic clk = 0, rst_n = 0, load = 0, lzb_en = 0;
  logic [15:0] value = 0;
  logic [3:0] dps = 0, digit_data, digit_sel;
  logic digit_dp, frame_start;
  int checks = 0, errors = 0;
  int n = -1;
  logic [15:0] m_shadow = 0, m_pend = 0;
  logic [3:0] m_sdp = 0, m_pdp = 0;
  bit m_pflag = 0, m_lzb = 0;

  seg_scan_ctrl #(.DIGITS(D), .PRESCALE(P), .BLANK(B), .SEL_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dps(dps), .load(load), .lzb_en(lzb_en),
    .digit_data(digit_data), .digit_dp(digit_dp), .digit_sel(digit_sel), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    logic [3:0] dp;
    logic lzb;
    logic [15:0] exp_data;
    logic [3:0] exp_dp;
    logic [3:0] exp_mask;
  } rec_t;
  rec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mpos();
    return n < 0 ? -1 : n % F;
  endfunction

  task automatic model_reset();
    n = -1; m_shadow = 0; m_pend = 0; m_sdp = 0; m_pdp = 0; m_pflag = 0;
  endtask

  // one clock: model advances on the edge, all outputs compared half a period later
  task automatic step();
    int pos, idx, cnt;
    logic bl;
    logic [3:0] esel;
    @(posedge clk);
    n++;
    if (n % F == 0 && m_pflag) begin m_shadow = m_pend; m_sdp = m_pdp; m_pflag = 0; end
    if (load) begin m_pend = value; m_pdp = dps; m_pflag = 1; end
    m_lzb = lzb_en;
    @(negedge clk);
    pos = n % F; idx = pos / P; cnt = pos % P;
    bl = m_lzb && idx > 0 && (m_shadow >> (4 * idx)) == 0 && !m_sdp[idx];
    esel = (cnt >= B && !bl) ? 4'(1 << idx) : 4'h0;
    chk("model_data", digit_data, 4'(m_shadow >> (4 * idx)));
    chk("model_dp", digit_dp, m_sdp[idx]);
    chk("model_sel", digit_sel, esel);
    chk("model_fs", frame_start, pos == 0);
  endtask

  task automatic run_to(input int t);
    for (int i = 0; i < F + 2 && mpos() != t; i++) step();
  endtask

  task automatic wait_fs(input string name);
    step();
    for (int i = 0; i < F + 2 && !frame_start; i++) step();
    chk(name, frame_start, 1);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dps = d; load = 1;
    step();
    load = 0;
  endtask

  task automatic capture(input rec_t r, input int id);
    logic [15:0] got_d;
    logic [3:0] got_dp, got_mask, early;
    got_d = 0; got_dp = 0; got_mask = 0; early = 0;
    for (int s = 0; s < F; s++) begin
      if (s > 0) step();
      if (s % P == 0) begin got_d[4*(s/P) +: 4] = digit_data; got_dp[s/P] = digit_dp; end
      if (s % P < B) early |= digit_sel; else got_mask |= digit_sel;
    end
    chk($sformatf("tbl%0d_data", id), got_d, r.exp_data);
    chk($sformatf("tbl%0d_dp", id), got_dp, r.exp_dp);
    chk($sformatf("tbl%0d_mask", id), got_mask, r.exp_mask);
    chk($sformatf("tbl%0d_blank_int", id), early, 0);
    step();
    chk($sformatf("tbl%0d_period", id), frame_start, 1);
  endtask

  task automatic async_reset(input string name);
    #2 rst_n = 0;
    #1;
    chk({name, "_sel"}, digit_sel, 0);
    chk({name, "_data"}, digit_data, 0);
    chk({name, "_dp"}, digit_dp, 0);
    chk({name, "_fs"}, frame_start, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    step();
    chk({name, "_restart_fs"}, frame_start, 1);
  endtask

  initial begin
    tbl[0] = '{16'h1A2B, 4'b0100, 0, 16'h1A2B, 4'b0100, 4'b1111};
    tbl[1] = '{16'h0050, 4'b0000, 1, 16'h0050, 4'b0000, 4'b0011};
    tbl[2] = '{16'h0050, 4'b0000, 0, 16'h0050, 4'b0000, 4'b1111};
    tbl[3] = '{16'h0000, 4'b0000, 1, 16'h0000, 4'b0000, 4'b0001};
    tbl[4] = '{16'h0050, 4'b1000, 1, 16'h0050, 4'b1000, 4'b1011};
    #1;
    chk("rst_sel", digit_sel, 0);
    chk("rst_fs", frame_start, 0);
    @(negedge clk);
    rst_n = 1;
    step();
    chk("first_fs", frame_start, 1);
    chk("first_data", digit_data, 0);
    foreach (tbl[i]) begin
      wait_fs("tbl_sync");
      step(); step();
      lzb_en = tbl[i].lzb;
      pulse_load(tbl[i].val, tbl[i].dp);
      wait_fs("tbl_swap");
      capture(tbl[i], i);
    end
    lzb_en = 0;
    pulse_load(16'h1A2B, 4'b0100);
    wait_fs("db_sync");
    run_to(9);
    pulse_load(16'h1234, 4'b0000);
    run_to(16); chk("db_old2", digit_data, 4'hA);
    run_to(24); chk("db_old3", digit_data, 4'h1);
    wait_fs("db_swap");
    chk("db_new0", digit_data, 4'h4);
    run_to(8); chk("db_new1", digit_data, 4'h3);
    run_to(16); chk("db_new2", digit_data, 4'h2);
    run_to(24); chk("db_new3", digit_data, 4'h1);
    run_to(12);
    chk("pre_rst_sel", digit_sel, 4'b0010);
    async_reset("midrst");
    chk("midrst_data", digit_data, 0);
    run_to(5);
    pulse_load(16'h5555, 4'b0000);
    run_to(F - 1);
    value = 16'h6666; load = 1;
    step();
    load = 0;
    chk("coinc_fs", frame_start, 1);
    chk("coinc_old", digit_data, 4'h5);
    run_to(F - 1);
    step();
    chk("coinc_new", digit_data, 4'h6);
    run_to(3);
    value = 16'h1111; load = 1;
    step();
    value = 16'h2222;
    step();
    load = 0;
    run_to(0); chk("b2b_d0", digit_data, 4'h2);
    run_to(20); chk("b2b_d2", digit_data, 4'h2);
    for (int c = 0; c < 1200; c++) begin
      for (int k = 0; k < D; k++) value[4*k +: 4] = ($urandom % 3 == 0) ? 4'($urandom) : 4'h0;
      dps = ($urandom % 4 == 0) ? 4'($urandom) : 4'h0;
      load = ($urandom % 6 == 0);
      if ($urandom % 16 == 0) lzb_en = ~lzb_en;
      if (c == 600) begin
        load = 0;
        async_reset("rndrst");
      end else step();
    end
    load = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit 7-segment display.
- Holds a DIGITS-wide hex value and per-digit decimal points in a double-buffered shadow register.
- Steps through the digits one slot at a time and presents each nibble plus its dp on digit_data/digit_dp, which feed the hex-to-segment decoder directly.
- Drives the one-hot digit_sel lines for the common pins, with an anti-ghosting blank interval and optional leading-zero blanking.

Parameters:
DIGITS, 4, number of digits scanned (legal 1..8)
PRESCALE, 1000, clock cycles per digit slot (legal > BLANK)
BLANK, 16, cycles at the start of each slot during which digit_sel is all-inactive (legal 0..PRESCALE-1)
SEL_ACTIVE_LOW, 0, 1 = digit_sel active level is 0; 0 = active level is 1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
value  in  4*DIGITS  hex digits; nibble k = digit k; digit 0 is least significant
dps  in  DIGITS  decimal point per digit, bit k = digit k
load  in  1  capture value/dps into pending buffer (1-cycle strobe)
lzb_en  in  1  leading-zero blanking enable
digit_data  out  4  nibble of current digit, to decoder indata
digit_dp  out  1  dp of current digit, to decoder dp
digit_sel  out  DIGITS  one-hot digit enable (polarity per SEL_ACTIVE_LOW)
frame_start  out  1  1-cycle pulse at start of digit-0 slot

Behaviour:
- Reset is asynchronous and takes effect without a clock edge. All of the following are reset:
  - cnt=0, idx=0, pending=0, pend_flag=0, shadow=0;
  - digit_data=0, digit_dp=0, frame_start=0;
  - digit_sel all-inactive (all 0, or all 1 if SEL_ACTIVE_LOW).
- Slot counter cnt counts 0..PRESCALE-1 and wraps. On wrap, idx advances 0..DIGITS-1 and wraps to 0.
- Frame period is DIGITS*PRESCALE cycles.
- Output timing: all outputs are flops loaded from the next-state (idx,cnt). Outputs therefore align with the internal idx/cnt, are glitch-free, and have no combinational path from inputs.
- digit_data = shadow nibble[idx]; digit_dp = shadow dps[idx]. Both are held for the whole slot, including the blank interval.
- digit_sel[idx] is active only when cnt >= BLANK and digit idx is not blanked. All other bits are inactive.
- Leading-zero blanking applies when lzb_en=1:
  - Digit k > 0 is blanked if shadow nibbles k..DIGITS-1 are all zero and shadow dps[k]=0.
  - Digit 0 is never blanked.
  - lzb_en is sampled live, not shadowed.
- frame_start=1 for exactly the one cycle where idx==0 and cnt==0.
- Double buffer:
  - load=1 captures value/dps into pending and sets pend_flag.
  - Back-to-back loads: last load wins.
  - On the edge entering (idx=0, cnt=0), if pend_flag=1: shadow<=pending and pend_flag<=0.
  - The swap always happens at a frame boundary, never mid-frame. The first frame after reset shows all zeros.
- Simultaneous load and swap edge:
  - The swap uses the pending contents from before the edge.
  - The new load is captured and pend_flag stays 1, so the new value is displayed from the following frame.
- Reset mid-slot aborts immediately. After reset release, scanning restarts at idx=0, cnt=0 with frame_start asserted in the first cycle.
- DIGITS=1: idx stays 0 and frame_start pulses every PRESCALE cycles.

Test Plan:
Common setup: DIGITS=4, PRESCALE=8, BLANK=2, SEL_ACTIVE_LOW=0.
1. Reset: assert rst_n=0 mid-slot, no clock -> digit_sel=0000, digit_data=0, digit_dp=0, frame_start=0 immediately. Release -> frame_start=1 in first cycle, idx=0.
2. Scan order: load value=16'h1A2B, dps=4'b0100, wait one frame boundary. Per slot:
   - idx0: digit_data=B, sel=0000 for cnt 0-1, then 0001 for cnt 2-7.
   - idx1: 2, sel=0010.
   - idx2: A, dp=1, sel=0100.
   - idx3: 1, sel=1000.
   - Period 32 cycles.
3. Double buffer: mid-frame load 16'h1234 -> remaining slots still show 1A2B. From next frame_start, digits show 4,3,2,1.
4. Leading-zero blanking: value=16'h0050, lzb_en=1 -> digit_sel bits 3 and 2 never active; digits 1 ('5') and 0 ('0') active.
   - lzb_en=0 -> all four active.
   - value=0, lzb_en=1 -> only digit 0 active.
   - value=16'h0050, dps=4'b1000, lzb_en=1 -> digit 3 active, digit 2 blanked.
5. Coincident load: load=1 on the cycle where the swap occurs -> swapped frame shows the previous pending value; the new value appears one frame later.
6. Back-to-back loads 16'h1111 then 16'h2222 within one frame -> next frame displays 2222 only.
